// File: rtl/retire_rat.sv
// Retirement register alias table.
// Holds the committed architectural-to-physical map. Each commit installs a new
// mapping and hands the displaced physical register back to the free list one
// cycle later. A flush streams the committed map, one entry per cycle, to the
// front-end RAT restore port.
module retire_rat #(
    parameter int ARCH_REGS  = 32,
    parameter int PHYS_REGS  = 64,
    parameter int PHYS_WIDTH = 6,
    parameter int ARCH_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  commit_valid_in,
    input  logic [ARCH_WIDTH-1:0] commit_arch_rd_in,
    input  logic [PHYS_WIDTH-1:0] commit_phys_rd_in,
    output logic                  free_enqueue_out,
    output logic [PHYS_WIDTH-1:0] free_wdata_out,
    input  logic                  flush_in,
    output logic                  busy_out,
    output logic                  restore_valid_out,
    output logic [ARCH_WIDTH-1:0] restore_arch_out,
    output logic [PHYS_WIDTH-1:0] restore_phys_out,
    output logic                  restore_done_out
);

    localparam logic [ARCH_WIDTH-1:0] LAST_IDX = ARCH_WIDTH'(ARCH_REGS - 1);

    typedef enum logic {
        IDLE    = 1'b0,
        RESTORE = 1'b1
    } state_t;

    state_t                  state_reg;
    state_t                  state_next;
    logic [ARCH_WIDTH-1:0]   idx_reg;
    logic [ARCH_WIDTH-1:0]   idx_next;
    logic [PHYS_WIDTH-1:0]   map_reg [ARCH_REGS];
    logic                    free_enqueue_reg;
    logic [PHYS_WIDTH-1:0]   free_wdata_reg;
    logic                    busy;
    logic                    commit_ok;

    assign busy = (state_reg == RESTORE);

    // x0 is hard-wired to physical 0, and the ROB is empty while restoring,
    // so commits in either case are dropped.
    assign commit_ok = commit_valid_in && (commit_arch_rd_in != '0) && !busy;

    // Committed map: identity after reset, one write port driven by commit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ARCH_REGS; i++) begin
                map_reg[i] <= PHYS_WIDTH'(i);
            end
        end else if (commit_ok) begin
            map_reg[commit_arch_rd_in] <= commit_phys_rd_in;
        end
    end

    // Return the displaced mapping to the free list one cycle after commit;
    // the data register holds its last value between enqueues.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            free_enqueue_reg <= 1'b0;
            free_wdata_reg   <= '0;
        end else begin
            free_enqueue_reg <= commit_ok;
            if (commit_ok) begin
                free_wdata_reg <= map_reg[commit_arch_rd_in];
            end
        end
    end

    assign free_enqueue_out = free_enqueue_reg;
    assign free_wdata_out   = free_wdata_reg;

    // Restore FSM state and entry index registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            idx_reg   <= '0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
        end
    end

    // Restore FSM next-state and stream outputs; a flush during a pass restarts it.
    always_comb begin
        state_next        = state_reg;
        idx_next          = idx_reg;
        busy_out          = 1'b0;
        restore_valid_out = 1'b0;
        restore_arch_out  = '0;
        restore_phys_out  = '0;
        restore_done_out  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (flush_in) begin
                    state_next = RESTORE;
                    idx_next   = '0;
                end
            end
            RESTORE: begin
                busy_out          = 1'b1;
                restore_valid_out = 1'b1;
                restore_arch_out  = idx_reg;
                restore_phys_out  = map_reg[idx_reg];
                restore_done_out  = (idx_reg == LAST_IDX);
                if (flush_in) begin
                    idx_next = '0;
                end else if (idx_reg == LAST_IDX) begin
                    state_next = IDLE;
                    idx_next   = '0;
                end else begin
                    idx_next = idx_reg + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                idx_next   = '0;
            end
        endcase
    end

    // A commit while the restore stream is running means the ROB was not drained.
    commit_while_busy_a: assert property (@(posedge clk) disable iff (!rst_n)
        !(commit_valid_in && busy))
        else $warning("retire_rat: commit while restore busy, ignored");

endmodule

// File: tb/tb_retire_rat.sv
// Self-checking bench for retire_rat: scoreboard queues for free-list returns
// and restore entries, plus per-scenario inline checks.
module tb_retire_rat;

    localparam int AW = 5;
    localparam int PW = 6;
    localparam int NR = 32;

    typedef struct packed {
        logic [AW-1:0] arch;
        logic [PW-1:0] phys;
        logic          done;
    } rest_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          commit_valid_in;
    logic [AW-1:0] commit_arch_rd_in;
    logic [PW-1:0] commit_phys_rd_in;
    logic          free_enqueue_out;
    logic [PW-1:0] free_wdata_out;
    logic          flush_in;
    logic          busy_out;
    logic          restore_valid_out;
    logic [AW-1:0] restore_arch_out;
    logic [PW-1:0] restore_phys_out;
    logic          restore_done_out;

    logic [PW-1:0] free_q [$];
    rest_t         rest_q [$];
    logic [PW-1:0] model_map [NR];
    int            compared   = 0;
    int            mismatched = 0;

    always #5 clk = ~clk;

    retire_rat #(
        .ARCH_REGS (32),
        .PHYS_REGS (64),
        .PHYS_WIDTH(PW),
        .ARCH_WIDTH(AW)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .commit_valid_in  (commit_valid_in),
        .commit_arch_rd_in(commit_arch_rd_in),
        .commit_phys_rd_in(commit_phys_rd_in),
        .free_enqueue_out (free_enqueue_out),
        .free_wdata_out   (free_wdata_out),
        .flush_in         (flush_in),
        .busy_out         (busy_out),
        .restore_valid_out(restore_valid_out),
        .restore_arch_out (restore_arch_out),
        .restore_phys_out (restore_phys_out),
        .restore_done_out (restore_done_out)
    );

    // Scoreboard: pop and compare whenever the DUT presents an enqueue or restore entry.
    always @(negedge clk) begin
        logic [PW-1:0] fexp;
        rest_t         rexp;
        if (rst_n) begin
            if (free_enqueue_out) begin
                compared++;
                if (free_q.size() == 0) begin
                    mismatched++;
                    $display("FAIL free_unexpected: got enqueue of %0d, required none", free_wdata_out);
                end else begin
                    fexp = free_q.pop_front();
                    if (free_wdata_out !== fexp) begin
                        mismatched++;
                        $display("FAIL free_wdata: got %0d required %0d", free_wdata_out, fexp);
                    end else begin
                        $display("free enqueue phys=%0d", free_wdata_out);
                    end
                end
            end
            if (restore_valid_out) begin
                compared++;
                if (rest_q.size() == 0) begin
                    mismatched++;
                    $display("FAIL restore_unexpected: got arch=%0d phys=%0d, required none",
                             restore_arch_out, restore_phys_out);
                end else begin
                    rexp = rest_q.pop_front();
                    if ({restore_arch_out, restore_phys_out, restore_done_out} !== rexp) begin
                        mismatched++;
                        $display("FAIL restore_entry: got arch=%0d phys=%0d done=%0b required arch=%0d phys=%0d done=%0b",
                                 restore_arch_out, restore_phys_out, restore_done_out,
                                 rexp.arch, rexp.phys, rexp.done);
                    end else begin
                        $display("restore arch=%0d phys=%0d done=%0b",
                                 restore_arch_out, restore_phys_out, restore_done_out);
                    end
                end
            end else if (restore_done_out) begin
                compared++;
                mismatched++;
                $display("FAIL done_without_valid: got done=1 required 0");
            end
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_model();
        for (int i = 0; i < NR; i++) model_map[i] = PW'(i);
    endtask

    task automatic push_pass(input int n, input bit with_done);
        rest_t e;
        for (int i = 0; i < n; i++) begin
            e.arch = AW'(i);
            e.phys = model_map[i];
            e.done = with_done && (i == NR - 1);
            rest_q.push_back(e);
        end
    endtask

    task automatic commit(input logic [AW-1:0] rd, input logic [PW-1:0] ph);
        commit_valid_in   = 1'b1;
        commit_arch_rd_in = rd;
        commit_phys_rd_in = ph;
        if (rd != 0) begin
            free_q.push_back(model_map[rd]);
            model_map[rd] = ph;
        end
        cycle();
        commit_valid_in = 1'b0;
    endtask

    task automatic flush_only();
        flush_in = 1'b1;
        push_pass(NR, 1'b1);
        cycle();
        flush_in = 1'b0;
    endtask

    // Count busy cycles until busy_out drops; an expired bound shows as a wrong count.
    task automatic wait_restore(input int exp_cycles, input string name);
        int n = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (busy_out) n++;
            else break;
        end
        compared++;
        if (n !== exp_cycles) begin
            mismatched++;
            $display("FAIL %s_busy_cycles: got %0d required %0d", name, n, exp_cycles);
        end else begin
            $display("%s busy for %0d cycles", name, n);
        end
    endtask

    task automatic test_reset();
        #12;
        compared++;
        if ({free_enqueue_out, free_wdata_out, busy_out, restore_valid_out,
             restore_arch_out, restore_phys_out, restore_done_out} !== '0) begin
            mismatched++;
            $display("FAIL reset_outputs_in_reset: got nonzero outputs required all 0");
        end
        #5 rst_n = 1'b1;
        cycle();
        compared++;
        if ({free_enqueue_out, free_wdata_out, busy_out, restore_valid_out,
             restore_arch_out, restore_phys_out, restore_done_out} !== '0) begin
            mismatched++;
            $display("FAIL reset_outputs_after_release: got nonzero outputs required all 0");
        end else begin
            $display("reset outputs all zero");
        end
        flush_only();
        wait_restore(32, "reset_identity");
    endtask

    task automatic test_commit();
        commit(5'd5, 6'd40);
        compared++;
        if (free_enqueue_out !== 1'b1 || free_wdata_out !== 6'd5) begin
            mismatched++;
            $display("FAIL commit_first: got enq=%0b data=%0d required enq=1 data=5",
                     free_enqueue_out, free_wdata_out);
        end
        commit(5'd5, 6'd41);
        compared++;
        if (free_enqueue_out !== 1'b1 || free_wdata_out !== 6'd40) begin
            mismatched++;
            $display("FAIL commit_back_to_back: got enq=%0b data=%0d required enq=1 data=40",
                     free_enqueue_out, free_wdata_out);
        end
        cycle();
        compared++;
        if (free_enqueue_out !== 1'b0 || free_wdata_out !== 6'd40) begin
            mismatched++;
            $display("FAIL commit_idle_hold: got enq=%0b data=%0d required enq=0 data=40",
                     free_enqueue_out, free_wdata_out);
        end
    endtask

    task automatic test_x0();
        commit(5'd0, 6'd33);
        compared++;
        if (free_enqueue_out !== 1'b0) begin
            mismatched++;
            $display("FAIL x0_no_enqueue: got enq=%0b required 0", free_enqueue_out);
        end
        flush_only();
        wait_restore(32, "x0_restore");
    endtask

    task automatic test_commit_flush();
        flush_in = 1'b1;
        commit_valid_in   = 1'b1;
        commit_arch_rd_in = 5'd7;
        commit_phys_rd_in = 6'd50;
        free_q.push_back(model_map[7]);
        model_map[7] = 6'd50;
        push_pass(NR, 1'b1);
        cycle();
        flush_in        = 1'b0;
        commit_valid_in = 1'b0;
        compared++;
        if (free_enqueue_out !== 1'b1 || free_wdata_out !== 6'd7) begin
            mismatched++;
            $display("FAIL commit_flush_free: got enq=%0b data=%0d required enq=1 data=7",
                     free_enqueue_out, free_wdata_out);
        end
        wait_restore(32, "commit_flush");
    endtask

    task automatic test_reflush();
        flush_in = 1'b1;
        push_pass(11, 1'b0);
        cycle();
        flush_in = 1'b0;
        repeat (10) cycle();
        flush_in = 1'b1;
        push_pass(NR, 1'b1);
        cycle();
        flush_in = 1'b0;
        wait_restore(32, "reflush");
    endtask

    task automatic test_reset_mid();
        commit(5'd3, 6'd60);
        cycle();
        flush_in = 1'b1;
        push_pass(21, 1'b0);
        cycle();
        flush_in = 1'b0;
        repeat (20) cycle();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        compared++;
        if (busy_out !== 1'b0 || restore_valid_out !== 1'b0 || restore_done_out !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_mid_abort: got busy=%0b valid=%0b done=%0b required 0 0 0",
                     busy_out, restore_valid_out, restore_done_out);
        end
        compared++;
        if (rest_q.size() != 0) begin
            mismatched++;
            $display("FAIL reset_mid_entries: got %0d entries outstanding required 0", rest_q.size());
            rest_q.delete();
        end
        reset_model();
        @(negedge clk);
        rst_n = 1'b1;
        cycle();
        flush_only();
        wait_restore(32, "reset_mid_identity");
    endtask

    task automatic test_busy_commit();
        flush_in = 1'b1;
        push_pass(NR, 1'b1);
        cycle();
        flush_in          = 1'b0;
        commit_valid_in   = 1'b1;
        commit_arch_rd_in = 5'd9;
        commit_phys_rd_in = 6'd55;
        cycle();
        commit_valid_in = 1'b0;
        compared++;
        if (free_enqueue_out !== 1'b0) begin
            mismatched++;
            $display("FAIL busy_commit_enqueue: got enq=%0b required 0", free_enqueue_out);
        end
        wait_restore(31, "busy_commit");
        flush_only();
        wait_restore(32, "busy_commit_table");
    endtask

    initial begin
        rst_n             = 1'b0;
        commit_valid_in   = 1'b0;
        commit_arch_rd_in = '0;
        commit_phys_rd_in = '0;
        flush_in          = 1'b0;
        reset_model();

        test_reset();
        test_commit();
        test_x0();
        test_commit_flush();
        test_reflush();
        test_reset_mid();
        test_busy_commit();

        repeat (3) cycle();
        compared++;
        if (free_q.size() != 0 || rest_q.size() != 0) begin
            mismatched++;
            $display("FAIL queues_drained: got free=%0d restore=%0d outstanding required 0 0",
                     free_q.size(), rest_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
